// File: rtl/bulls_cows_referee.sv
// rtl/bulls_cows_referee.sv - Bulls and Cows referee: answer generation, guess scoring, game tracking.
// Define BC_FIXED_ANSWER_EN to load FIXED_ANSWER instead of drawing digits from the LFSR.
module bulls_cows_referee #(
   parameter int          MAX_TRIES    = 10,
   parameter logic [15:0] SEED         = 16'hACE1,
   parameter logic [15:0] FIXED_ANSWER = 16'h1234
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_game,
   input  logic        guess_valid,
   input  logic [15:0] guess,
   output logic        guess_ready,
   output logic        result_valid,
   output logic [2:0]  strike,
   output logic [2:0]  ball,
   output logic        guess_err,
   output logic        win,
   output logic        lose,
   output logic [3:0]  tries,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, GEN, READY, SCORE, RESULT, DONE} state_t;

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [3:0]  MAX_T    = 4'(MAX_TRIES);

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] answer_q, answer_d;
   logic [15:0] guess_q, guess_d;
   logic [1:0]  idx_q, idx_d;
   logic [2:0]  strike_q, strike_d;
   logic [2:0]  ball_q, ball_d;
   logic        err_q, err_d;
   logic        win_q, win_d;
   logic        lose_q, lose_d;
   logic [3:0]  tries_q, tries_d;

   logic [3:0]  g_dig, a_dig, tries_inc;
   logic        is_strike, is_ball;
   logic [2:0]  strike_new, ball_new;
`ifndef BC_FIXED_ANSWER_EN
   logic [3:0]  cand;
   logic        cand_ok;
   logic [15:0] slot_mask;
`endif

   function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
      case (i)
         2'd0:    return v[15:12];
         2'd1:    return v[11:8];
         2'd2:    return v[7:4];
         default: return v[3:0];
      endcase
   endfunction

   function automatic logic bad_guess(input logic [15:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (nib(v, 2'(i)) > 4'd9) bad = 1'b1;
         for (int j = i + 1; j < 4; j++)
            if (nib(v, 2'(i)) == nib(v, 2'(j))) bad = 1'b1;
      end
      return bad;
   endfunction

   always_comb begin
      state_d  = state_q;
      answer_d = answer_q;
      guess_d  = guess_q;
      idx_d    = idx_q;
      strike_d = strike_q;
      ball_d   = ball_q;
      err_d    = err_q;
      win_d    = win_q;
      lose_d   = lose_q;
      tries_d  = tries_q;
      lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

      g_dig      = nib(guess_q, idx_q);
      a_dig      = nib(answer_q, idx_q);
      is_strike  = (g_dig == a_dig);
      // A digit that misses its own slot but matches any slot must match another one.
      is_ball    = !is_strike && ((g_dig == nib(answer_q, 2'd0)) || (g_dig == nib(answer_q, 2'd1)) ||
                                  (g_dig == nib(answer_q, 2'd2)) || (g_dig == nib(answer_q, 2'd3)));
      strike_new = strike_q + {2'b00, is_strike};
      ball_new   = ball_q + {2'b00, is_ball};
      tries_inc  = (tries_q == 4'd15) ? 4'd15 : tries_q + 4'd1;

`ifndef BC_FIXED_ANSWER_EN
      cand    = lfsr_q[3:0];
      cand_ok = (cand <= 4'd9);
      for (int j = 0; j < 3; j++)
         if ((j < int'(idx_q)) && (nib(answer_q, 2'(j)) == cand)) cand_ok = 1'b0;
      slot_mask = 16'hF000 >> {idx_q, 2'b00};
`endif

      case (state_q)
         GEN: begin
`ifdef BC_FIXED_ANSWER_EN
            answer_d = FIXED_ANSWER;
            state_d  = READY;
`else
            if (cand_ok) begin
               answer_d = (answer_q & ~slot_mask) | ({cand, 12'h000} >> {idx_q, 2'b00});
               idx_d    = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = READY;
            end
`endif
         end
         READY: begin
            if (guess_valid) begin
               guess_d  = guess;
               strike_d = 3'd0;
               ball_d   = 3'd0;
               idx_d    = 2'd0;
               if (bad_guess(guess)) begin
                  err_d   = 1'b1;
                  state_d = RESULT;
               end else begin
                  err_d   = 1'b0;
                  state_d = SCORE;
               end
            end
         end
         SCORE: begin
            strike_d = strike_new;
            ball_d   = ball_new;
            idx_d    = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = RESULT;
               tries_d = tries_inc;
               if (strike_new == 3'd4) win_d = 1'b1;
               else if (tries_inc == MAX_T) lose_d = 1'b1;
            end
         end
         RESULT:  state_d = (win_q || lose_q) ? DONE : READY;
         default: ;
      endcase

      if (new_game) begin
         state_d  = GEN;
         idx_d    = 2'd0;
         tries_d  = 4'd0;
         strike_d = 3'd0;
         ball_d   = 3'd0;
         err_d    = 1'b0;
         win_d    = 1'b0;
         lose_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED_EFF;
         answer_q <= 16'h0000;
         guess_q  <= 16'h0000;
         idx_q    <= 2'd0;
         strike_q <= 3'd0;
         ball_q   <= 3'd0;
         err_q    <= 1'b0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
         tries_q  <= 4'd0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         answer_q <= answer_d;
         guess_q  <= guess_d;
         idx_q    <= idx_d;
         strike_q <= strike_d;
         ball_q   <= ball_d;
         err_q    <= err_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
         tries_q  <= tries_d;
      end
   end

   assign guess_ready  = (state_q == READY);
   assign result_valid = (state_q == RESULT);
   assign guess_err    = err_q & result_valid;
   assign strike       = strike_q;
   assign ball         = ball_q;
   assign win          = win_q;
   assign lose         = lose_q;
   assign tries        = tries_q;
   assign busy         = (state_q == GEN) || (state_q == SCORE);

endmodule

// File: tb/tb_bulls_cows_referee.sv
// tb/tb_bulls_cows_referee.sv - Scoreboard bench for bulls_cows_referee; answer predicted by an LFSR model.
module tb_bulls_cows_referee;
   localparam int          MAX_TRIES = 10;
   localparam logic [15:0] SEED      = 16'hACE1;
   localparam logic [15:0] FIXED     = 16'h1234;

   logic        clk = 1'b0;
   logic        rst, new_game, guess_valid;
   logic [15:0] guess;
   logic        guess_ready, result_valid, guess_err, win, lose, busy;
   logic [2:0]  strike, ball;
   logic [3:0]  tries;

   bulls_cows_referee #(.MAX_TRIES(MAX_TRIES), .SEED(SEED), .FIXED_ANSWER(FIXED)) u_dut (
      .clk(clk), .rst(rst), .new_game(new_game), .guess_valid(guess_valid), .guess(guess),
      .guess_ready(guess_ready), .result_valid(result_valid), .strike(strike), .ball(ball),
      .guess_err(guess_err), .win(win), .lose(lose), .tries(tries), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] s, b;
      logic       e, w, l;
      logic [3:0] t;
      int         acc, lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0, n_mis = 0, cyc = 0, exp_tries = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model of the answer draw: same LFSR, same rejection rule, same timing.
   logic [15:0] m_lfsr, m_ans;
   logic        m_gen;
   int          m_cnt;
   always @(posedge clk or posedge rst) begin : model
      logic [15:0] a;
      logic [3:0]  c;
      logic        ok, g;
      int          n;
      if (rst) begin
         m_lfsr <= SEED;
         m_ans  <= 16'h0;
         m_gen  <= 1'b0;
         m_cnt  <= 0;
      end else begin
         a = m_ans; n = m_cnt; g = m_gen;
         if (new_game) begin
            g = 1'b1; n = 0;
`ifdef BC_FIXED_ANSWER_EN
            a = FIXED;
`endif
         end else if (g) begin
`ifdef BC_FIXED_ANSWER_EN
            g = 1'b0;
`else
            c  = m_lfsr[3:0];
            ok = (c <= 4'd9);
            for (int k = 0; k < n; k++) if (a[15-4*k -: 4] == c) ok = 1'b0;
            if (ok) begin
               a[15-4*n -: 4] = c;
               n++;
               if (n == 4) g = 1'b0;
            end
`endif
         end
         m_ans  <= a;
         m_cnt  <= n;
         m_gen  <= g;
         m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (!rst && result_valid) begin
         if (sb.size() == 0) chk("unexpected_result", 32'(sb.size()), 1);
         else begin
            e = sb.pop_front();
            chk("strike", strike, e.s);
            chk("ball", ball, e.b);
            chk("guess_err", guess_err, e.e);
            chk("win", win, e.w);
            chk("lose", lose, e.l);
            chk("tries", tries, e.t);
            chk("latency", 32'(cyc - e.acc), e.lat);
         end
      end
   end

   function automatic logic [3:0] d(input int k);
      logic [15:0] a;
      a = m_ans;
      return a[15-4*k -: 4];
   endfunction

   function automatic logic [15:0] disjoint();
      logic [15:0] r;
      int n;
      r = 16'h0; n = 0;
      for (int v = 0; v < 10; v++)
         if (n < 4 && d(0) != 4'(v) && d(1) != 4'(v) && d(2) != 4'(v) && d(3) != 4'(v)) begin
            r[15-4*n -: 4] = 4'(v);
            n++;
         end
      return r;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, guess_ready, 0);
      chk({tag, "_rvalid"}, result_valid, 0);
      chk({tag, "_strike"}, strike, 0);
      chk({tag, "_ball"}, ball, 0);
      chk({tag, "_win"}, win, 0);
      chk({tag, "_lose"}, lose, 0);
      chk({tag, "_tries"}, tries, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (guess_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", guess_ready, 1);
   endtask

   task automatic start_game();
      new_game = 1'b1;
      @(negedge clk);
      new_game  = 1'b0;
      exp_tries = 0;
      chk("gen_busy", busy, 1);
      chk("gen_tries", tries, 0);
      wait_ready();
      chk("answer_model", u_dut.answer_q, m_ans);
   endtask

   task automatic send(input logic [15:0] g, input int s, input int b, input bit err);
      exp_t e;
      wait_ready();
      if (!err && exp_tries < 15) exp_tries++;
      e.s = 3'(s); e.b = 3'(b); e.e = err;
      e.w = !err && s == 4;
      e.l = !err && s != 4 && exp_tries == MAX_TRIES;
      e.t = 4'(exp_tries);
      e.acc = cyc + 1;
      e.lat = err ? 0 : 4;
      sb.push_back(e);
      guess = g; guess_valid = 1'b1;
      @(negedge clk);
      guess_valid = 1'b0;
      repeat (err ? 1 : 5) @(negedge clk);
   endtask

   initial begin
      logic [15:0] dis, a, first;
      logic        ok, differ;
      rst = 1'b1; new_game = 1'b0; guess_valid = 1'b0; guess = 16'h0;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst = 1'b0;
      @(negedge clk);
      check_zero("idle");

      start_game();
      send(m_ans, 4, 0, 0);
      chk("win_done_ready", guess_ready, 0);
      chk("win_hold", win, 1);

      start_game();
      dis = disjoint();
      send({d(3), d(2), d(1), d(0)}, 0, 4, 0);
      send({d(0), d(1), d(3), d(2)}, 2, 2, 0);
      send(dis, 0, 0, 0);
      send({d(0), d(0), d(1), d(2)}, 0, 0, 1);
      send({d(0), d(1), 4'hA, d(3)}, 0, 0, 1);
      repeat (7) send(dis, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("lose_ready_low", guess_ready, 0);
         @(negedge clk);
      end
      chk("lose_hold", lose, 1);
      chk("lose_tries", tries, MAX_TRIES);

      start_game();
      guess = m_ans; guess_valid = 1'b1; new_game = 1'b1;
      @(negedge clk);
      guess_valid = 1'b0; new_game = 1'b0; exp_tries = 0;
      chk("collide_busy", busy, 1);
      chk("collide_tries", tries, 0);
      wait_ready();
      send(m_ans, 4, 0, 0);

      start_game();
      guess = m_ans; guess_valid = 1'b1;
      @(negedge clk);
      guess_valid = 1'b0;
      @(negedge clk);
      chk("score_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      differ = 1'b0;
      first  = 16'h0;
      for (int gm = 0; gm < 200; gm++) begin
         repeat ($urandom_range(0, 15)) @(negedge clk);
         start_game();
         a  = u_dut.answer_q;
         ok = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (a[15-4*i -: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++) if (a[15-4*i -: 4] == a[15-4*j -: 4]) ok = 1'b0;
         end
         chk("answer_legal", ok, 1);
         if (gm == 0) first = a;
         else if (a != first) differ = 1'b1;
      end
`ifndef BC_FIXED_ANSWER_EN
      chk("answers_vary", differ, 1);
`endif

      repeat (10) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
